// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state set and flag bit positions for multicycle_alu.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_SHR  = 5'b00101,
    OP_SHRA = 5'b00110,
    OP_SHL  = 5'b00111,
    OP_ROR  = 5'b01000,
    OP_ROL  = 5'b01001,
    OP_AND  = 5'b01010,
    OP_OR   = 5'b01011,
    OP_MUL  = 5'b01111,
    OP_DIV  = 5'b10000,
    OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_ITER,
    S_DONE
  } state_e;

  localparam int FLG_ILLEGAL = 3;
  localparam int FLG_DIVZ    = 2;
  localparam int FLG_OVF     = 1;
  localparam int FLG_ZERO    = 0;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative signed multiply (shift-add) and restoring divide on operand magnitudes,
// one bit per cycle, with the sign fix-up applied on the output.
module seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               load_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic [CW-1:0]    cnt_q;
  logic             run_q;
  logic             div_q;
  logic             neg_lo_q;
  logic             neg_hi_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] trial;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load_i) begin
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST - 1'b1) run_q <= 1'b0;
    end
  end

  // hi/lo: product {hi,lo} for multiply, {remainder,quotient} for divide
  always_ff @(posedge clk) begin
    if (load_i) begin
      m_q      <= mag(b_i);
      hi_q     <= '0;
      lo_q     <= mag(a_i);
      div_q    <= is_div_i;
      neg_lo_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
      neg_hi_q <= a_i[WIDTH-1];
    end else if (run_q) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    trial = {1'b0, hi_q, lo_q[WIDTH-1]} - {2'b00, m_q};
    if (div_q) begin
      if (!trial[WIDTH+1]) begin
        hi_d = trial[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_mag = {hi_q, lo_q};
    prod_fix = neg_lo_q ? (~prod_mag + 1'b1) : prod_mag;
    quo_fix  = neg_lo_q ? (~lo_q + 1'b1) : lo_q;
    rem_fix  = neg_hi_q ? (~hi_q + 1'b1) : hi_q;
    result_o = div_q ? {rem_fix, quo_fix} : prod_fix;
  end

  assign done_o = (cnt_q == LAST);

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle ops evaluated from latched operands, Mul/Div delegated
// to seq_muldiv; results and flags registered and held until the next accepted start.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic [4:0]         Opcode,
  input  logic [WIDTH-1:0]   Ry,
  input  logic [WIDTH-1:0]   Rb,
  output logic [2*WIDTH-1:0] C_out,
  output logic               busy,
  output logic               done,
  output logic [3:0]         flags
);

  localparam int M = WIDTH - 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state_q;
  logic [4:0]         op_q;
  logic [WIDTH-1:0]   ry_q;
  logic [WIDTH-1:0]   rb_q;
  logic               ovf_pend_q;
  logic [2*WIDTH-1:0] c_out_q;
  logic [3:0]         flags_q;
  logic               busy_q;
  logic               done_q;

  logic               start_iter;
  logic               md_load;
  logic               md_done;
  logic [2*WIDTH-1:0] md_res;

  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   sum, diff, lo, hi;
  logic [2*WIDTH-1:0] rot;
  logic               legal, ovf, divz;
  logic [2*WIDTH-1:0] exec_res;
  logic [3:0]         exec_flags;

  // Only Mul and Div with a nonzero divisor need the iterative path
  assign start_iter = (Opcode == OP_MUL) || ((Opcode == OP_DIV) && (Rb != '0));
  assign md_load    = (state_q == S_IDLE) && start && start_iter;

  seq_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .clr_n    (clr_n),
    .load_i   (md_load),
    .is_div_i (Opcode == OP_DIV),
    .a_i      (Ry),
    .b_i      (Rb),
    .done_o   (md_done),
    .result_o (md_res)
  );

  always_comb begin
    sh    = rb_q[SHW-1:0];
    sum   = ry_q + rb_q;
    diff  = ry_q - rb_q;
    rot   = '0;
    lo    = '0;
    hi    = '0;
    legal = 1'b1;
    ovf   = 1'b0;
    divz  = 1'b0;
    case (op_q)
      OP_ADD: begin
        lo  = sum;
        ovf = (ry_q[M] == rb_q[M]) && (sum[M] != ry_q[M]);
      end
      OP_SUB: begin
        lo  = diff;
        ovf = (ry_q[M] != rb_q[M]) && (diff[M] != ry_q[M]);
      end
      OP_SHR:  lo = ry_q >> sh;
      OP_SHRA: lo = $signed(ry_q) >>> sh;
      OP_SHL:  lo = ry_q << sh;
      OP_ROR: begin
        rot = {ry_q, ry_q} >> sh;
        lo  = rot[WIDTH-1:0];
      end
      OP_ROL: begin
        rot = {ry_q, ry_q} << sh;
        lo  = rot[2*WIDTH-1:WIDTH];
      end
      OP_AND: lo = ry_q & rb_q;
      OP_OR:  lo = ry_q | rb_q;
      OP_NEG: lo = '0 - ry_q;
      OP_NOT: lo = ~ry_q;
      // Only a zero divisor reaches EXEC with Div
      OP_DIV: begin
        divz = 1'b1;
        lo   = '1;
        hi   = ry_q;
      end
      OP_MUL: lo = '0;
      default: legal = 1'b0;
    endcase
    exec_res                = {hi, lo};
    exec_flags              = '0;
    exec_flags[FLG_ILLEGAL] = !legal;
    exec_flags[FLG_DIVZ]    = divz;
    exec_flags[FLG_OVF]     = ovf;
    exec_flags[FLG_ZERO]    = (exec_res == '0);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      ry_q       <= '0;
      rb_q       <= '0;
      ovf_pend_q <= 1'b0;
      c_out_q    <= '0;
      flags_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q       <= Opcode;
            ry_q       <= Ry;
            rb_q       <= Rb;
            flags_q    <= '0;
            busy_q     <= 1'b1;
            ovf_pend_q <= (Opcode == OP_DIV) && (Ry == MOST_NEG) && (Rb == '1);
            state_q    <= start_iter ? S_ITER : S_EXEC;
          end
        end
        S_EXEC: begin
          c_out_q <= exec_res;
          flags_q <= exec_flags;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_ITER: begin
          if (md_done) begin
            c_out_q           <= md_res;
            flags_q           <= '0;
            flags_q[FLG_OVF]  <= ovf_pend_q;
            flags_q[FLG_ZERO] <= (md_res == '0);
            busy_q            <= 1'b0;
            done_q            <= 1'b1;
            state_q           <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign C_out = c_out_q;
  assign flags = flags_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
